segment_request_gen: RTL

- Stage directly downstream of the weighted random segment chooser.
- Consumes the chosen 2-bit segment number and turns it into memory-controller traffic requests: address = per-segment base + LFSR-generated offset, plus a read/write flag.
- Presents requests on a valid/ready interface to the controller front end.
- Throttles the chooser through its enable, and counts a programmed number of requests per run.

---
 rtl/segment_request_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/segment_request_gen.sv
// Turns chooser segment numbers into base+LFSR-offset memory requests on a valid/ready port.
// Define SEGMENT_REQUEST_GEN_STATS_EN to add saturating per-segment accepted-request counters.
module segment_request_gen #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 10,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic                    in_enable,
  input  logic [1:0]              in_segment_number,
  input  logic [ADDR_WIDTH-1:0]   in_base0,
  input  logic [ADDR_WIDTH-1:0]   in_base1,
  input  logic [ADDR_WIDTH-1:0]   in_base2,
  input  logic [ADDR_WIDTH-1:0]   in_base3,
  input  logic [OFFSET_WIDTH-1:0] in_seed,
  input  logic [1:0]              in_write_mode,
  input  logic [COUNT_WIDTH-1:0]  in_num_requests,
  input  logic                    in_req_ready,
  output logic                    out_choose_enable,
  output logic                    out_req_valid,
  output logic [ADDR_WIDTH-1:0]   out_req_addr,
  output logic                    out_req_write,
  output logic                    out_busy,
  output logic                    out_done
`ifdef SEGMENT_REQUEST_GEN_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0]  out_seg_count0,
  output logic [COUNT_WIDTH-1:0]  out_seg_count1,
  output logic [COUNT_WIDTH-1:0]  out_seg_count2,
  output logic [COUNT_WIDTH-1:0]  out_seg_count3
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [OFFSET_WIDTH-1:0] lfsr;
  logic [COUNT_WIDTH-1:0]  issued;
  logic [COUNT_WIDTH-1:0]  num_latched;
  logic [1:0]              mode_latched;
  logic                    aborting;
  logic [ADDR_WIDTH-1:0]   base_sel;
  logic                    slot;
  logic                    transfer;
  logic                    run_start;

  assign transfer  = out_req_valid && in_req_ready;
  assign run_start = (state == IDLE) && in_enable && (in_num_requests != '0);
  assign slot      = (state == RUN) && in_enable && !aborting &&
                     (issued < num_latched) && (!out_req_valid || in_req_ready);

  assign out_choose_enable = slot;
  assign out_busy          = (state == RUN);
  assign out_done          = (state == DONE);

  always_comb begin
    base_sel = in_base0;
    case (in_segment_number)
      2'd0: base_sel = in_base0;
      2'd1: base_sel = in_base1;
      2'd2: base_sel = in_base2;
      2'd3: base_sel = in_base3;
      default: base_sel = in_base0;
    endcase
  end

  // Once enable drops in RUN, the aborting flag keeps a re-raised enable from restarting slots
  // until the pending request has drained and the FSM is back in IDLE.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state         <= IDLE;
      lfsr          <= OFFSET_WIDTH'(1);
      issued        <= '0;
      num_latched   <= '0;
      mode_latched  <= '0;
      aborting      <= 1'b0;
      out_req_valid <= 1'b0;
      out_req_addr  <= '0;
      out_req_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_enable) begin
            if (in_num_requests != '0) begin
              state        <= RUN;
              lfsr         <= (in_seed == '0) ? OFFSET_WIDTH'(1) : in_seed;
              issued       <= '0;
              num_latched  <= in_num_requests;
              mode_latched <= in_write_mode;
              aborting     <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (transfer)
            out_req_valid <= 1'b0;
          if (slot) begin
            out_req_valid <= 1'b1;
            out_req_addr  <= base_sel + {{(ADDR_WIDTH-OFFSET_WIDTH){1'b0}}, lfsr};
            out_req_write <= mode_latched[1] ? lfsr[0] : mode_latched[0];
            issued        <= issued + 1'b1;
            lfsr          <= {lfsr[OFFSET_WIDTH-2:0], lfsr[9] ^ lfsr[6]};
          end
          if (aborting || !in_enable) begin
            if (!out_req_valid || transfer) begin
              state    <= IDLE;
              aborting <= 1'b0;
            end else begin
              aborting <= 1'b1;
            end
          end else if (transfer && (issued == num_latched)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!in_enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEGMENT_REQUEST_GEN_STATS_EN
  logic [1:0]             req_seg;
  logic [COUNT_WIDTH-1:0] seg_count [4];

  // The segment travels with the pending request so the count lands on the accepting edge.
  always_ff @(posedge in_clock) begin
    if (in_reset || run_start) begin
      req_seg <= '0;
      for (int i = 0; i < 4; i++)
        seg_count[i] <= '0;
    end else begin
      if (slot)
        req_seg <= in_segment_number;
      if (transfer && (state == RUN) && (seg_count[req_seg] != '1))
        seg_count[req_seg] <= seg_count[req_seg] + 1'b1;
    end
  end

  assign out_seg_count0 = seg_count[0];
  assign out_seg_count1 = seg_count[1];
  assign out_seg_count2 = seg_count[2];
  assign out_seg_count3 = seg_count[3];
`endif

endmodule
